// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the RAM word, the RAM status encoding and the
// arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        DHOLD  = 2'd3
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Arbiter-local constants and the saturating starvation-count helper.
package mem_arbiter_pkg;

    import cpu_types_pkg::*;

    localparam int STARVE_W = 8;

    typedef logic [STARVE_W-1:0] starve_t;

    localparam starve_t STARVE_ZERO = 8'd0;
    localparam word_t   WORD_ZERO   = 32'h0000_0000;

    // Advance the count of data grants taken over a waiting icache,
    // holding at the limit once reached.
    function automatic starve_t starve_inc(input starve_t cur, input starve_t lim);
        starve_t nxt;
        if (cur >= lim) begin
            nxt = lim;
        end else begin
            nxt = cur + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM-side signals around the arbiter.
// slave: the arbiter's view; master: the caches/RAM side (testbench).
interface mem_arbiter_if;

    // icache side
    logic                      iREN;
    cpu_types_pkg::word_t      iaddr;
    logic                      iwait;
    cpu_types_pkg::word_t      iload;

    // dcache side
    logic                      dREN;
    logic                      dWEN;
    cpu_types_pkg::word_t      daddr;
    cpu_types_pkg::word_t      dstore;
    logic                      dlock;
    logic                      dwait;
    cpu_types_pkg::word_t      dload;

    // RAM side
    logic                      ramREN;
    logic                      ramWEN;
    cpu_types_pkg::word_t      ramaddr;
    cpu_types_pkg::word_t      ramstore;
    cpu_types_pkg::word_t      ramload;
    cpu_types_pkg::ramstate_t  ramstate;
    logic                      memerr;

    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, daddr, dstore, dlock,
        input  ramload, ramstate,
        output iwait, iload,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output memerr
    );

    modport master (
        output iREN, iaddr,
        output dREN, dWEN, daddr, dstore, dlock,
        output ramload, ramstate,
        input  iwait, iload,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  memerr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache. Data side has
// priority; a starvation count forces an icache grant after STARVE_MAX
// data grants taken while the icache waited. dlock parks the grant in
// DHOLD between words of a multi-word dcache transfer.
module mem_arbiter
    import cpu_types_pkg::*, mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic           CLK,
    input  logic           RST,
    mem_arbiter_if.slave   bus
);

    localparam starve_t STARVE_LIM = starve_t'(STARVE_MAX);

    arbstate_t state_q;
    arbstate_t state_d;
    starve_t   starve_q;
    starve_t   starve_d;
    logic      d_req_s;
    logic      i_forced_s;

    assign d_req_s    = bus.dREN | bus.dWEN;
    assign i_forced_s = bus.iREN & (starve_q == STARVE_LIM);

    // State and starvation-count registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= STARVE_ZERO;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next-state and starvation-count update.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (d_req_s && !i_forced_s) begin
                    state_d = DGRANT;
                    if (bus.iREN) begin
                        starve_d = starve_inc(starve_q, STARVE_LIM);
                    end else begin
                        starve_d = STARVE_ZERO;
                    end
                end else if (bus.iREN) begin
                    state_d  = IGRANT;
                    starve_d = STARVE_ZERO;
                end else begin
                    state_d  = IDLE;
                    starve_d = STARVE_ZERO;
                end
            end
            IGRANT: begin
                if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
                    state_d = IDLE;
                end else begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                // An abandoned request releases the port without completing.
                if (!d_req_s) begin
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    if (bus.dlock) begin
                        state_d = DHOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.ramstate == ERROR) begin
                    state_d = IDLE;
                end else begin
                    state_d = DGRANT;
                end
            end
            DHOLD: begin
                // Next locked word goes straight back to DGRANT, no bubble.
                if (d_req_s) begin
                    state_d = DGRANT;
                end else if (!bus.dlock) begin
                    state_d = IDLE;
                end else begin
                    state_d = DHOLD;
                end
            end
            default: begin
                state_d  = IDLE;
                starve_d = STARVE_ZERO;
            end
        endcase
    end

    // RAM drive and cache completion outputs, decoded from the grant
    // state and the live RAM status.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = WORD_ZERO;
        bus.ramstore = WORD_ZERO;
        bus.iwait    = 1'b1;
        bus.iload    = WORD_ZERO;
        bus.dwait    = 1'b1;
        bus.dload    = WORD_ZERO;
        bus.memerr   = 1'b0;
        case (state_q)
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (bus.ramstate == ACCESS) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end else if (bus.ramstate == ERROR) begin
                    bus.memerr = 1'b1;
                end else begin
                    bus.iwait = 1'b1;
                end
            end
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                // Write wins when both enables are raised.
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (d_req_s && bus.ramstate == ACCESS) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                end else if (d_req_s && bus.ramstate == ERROR) begin
                    bus.memerr = 1'b1;
                end else begin
                    bus.dwait = 1'b1;
                end
            end
            default: begin
                // IDLE and DHOLD drive nothing onto the RAM.
                bus.ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single RAM port between the instruction cache and the data cache. Sits between the two L1 caches and the memory/RAM model, grants one requester at a time, and drives the RAM address, enable and store lines from the granted requester. Data-side requests take priority. A starvation counter guarantees instruction fetch progress, and a lock input keeps multi-word data-cache transfers atomic.

## Interface
- STARVE_MAX, default 4: consecutive data grants allowed while an instruction request waits before the instruction side is forced.
- CLK  in  1  system clock, rising edge
- RST  in  1  reset; one clock, asynchronous, active-high
- iREN  in  1  icache read request, held until iwait falls
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the cycle the icache read completes
- iload  out  32  icache read data, valid when iwait=0
- dREN, dWEN  in  1 each  dcache read/write request, held until dwait falls
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dlock  in  1  dcache multi-word transfer in progress (hold grant between words)
- dwait  out  1  low for exactly the cycle the dcache access completes
- dload  out  32  dcache read data, valid when dwait=0
- ramREN, ramWEN  out  1 each  RAM read/write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR
- memerr  out  1  one-cycle pulse when a granted access ends in ERROR

## Operation
- States: IDLE, IGRANT, DGRANT, DHOLD. Registered. RST forces IDLE, starve count 0.
- IDLE: no RAM enables.
  - If (dREN|dWEN) and not (iREN and starve==STARVE_MAX), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- IGRANT:
  - ramREN=1, ramaddr=iaddr.
  - On ACCESS: iwait=0, iload=ramload, go to IDLE.
  - On ERROR: memerr=1, go to IDLE, iwait stays 1.
  - On BUSY or FREE: stay.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore. ramWEN=dWEN. ramREN=dREN&~dWEN (write wins if both are high).
  - On ACCESS: dwait=0, dload=ramload. Go to DHOLD if dlock=1, else IDLE.
  - On ERROR: memerr=1, go to IDLE.
  - If dREN and dWEN are both low before completion (abandoned request), go to IDLE.
- DHOLD: no RAM enables, icache not grantable.
  - If dREN|dWEN, go to DGRANT.
  - Else if dlock=0, go to IDLE.
  - Else stay in DHOLD.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each IDLE→DGRANT transition taken while iREN=1.
  - Clears on IDLE→IGRANT, or in IDLE with iREN=0.
  - DHOLD→DGRANT does not increment.
- All outputs are combinational from state and ramstate. Ungranted wait=1; ungranted load=0.

## Timing
- Reset values: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, memerr=0.
- Grant latency: request seen in IDLE at cycle n, RAM enables asserted in cycle n+1.
- Minimum access is 2 cycles (grant, then ACCESS). Each BUSY cycle adds one.
- Mandatory one IDLE cycle after every completion, so a requester's still-high REN in the completion+1 cycle is not re-issued.
- DHOLD→DGRANT skips the IDLE bubble. The second word is driven on the cycle after REN/WEN is seen in DHOLD.
- RST asserted mid-access clears the state immediately (asynchronous). RAM enables drop the same cycle; no completion is signalled.
- ramstate ACCESS arriving while in IDLE or DHOLD is ignored.

## Structure
- cpu_types_pkg holds the ramstate_t enum (FREE=0, BUSY=1, ACCESS=2, ERROR=3) and word_t. Add the arbiter state enum there as arbstate_t.
- Single module. No sub-module is needed; the starve counter stays inline.

## Test plan
- iREN=1 only, iaddr=0x40, ramstate BUSY×2 then ACCESS with ramload=0xDEADBEEF. Expect ramREN one cycle after request, iwait=0 and iload=0xDEADBEEF on the ACCESS cycle only, then IDLE.
- iREN and dWEN both raised in the same cycle, daddr=0x80, dstore=0x1234. Expect the data write granted first (ramWEN=1, ramstore=0x1234). After its ACCESS plus one IDLE cycle, the icache read is granted.
- iREN held while dREN re-requests continuously, STARVE_MAX=4. Expect exactly 4 data grants, then an icache grant, then the counter cleared.
- dlock=1 across two dREN words at 0x100 and 0x104, with iREN pending. Expect no icache grant until dlock falls, and no IDLE bubble between the data words.
- Granted icache read receives ramstate=ERROR. Expect memerr pulses one cycle, iwait stays 1, IDLE follows, and a retry is granted.
- RST asserted during DGRANT with ramstate=BUSY. Expect ramREN/ramWEN=0 and dwait=1 immediately, and IDLE after release.
